// File: rtl/ball_controller.sv
// ball_controller: owns the ball position and direction, wall and paddle
// bounces, point detection, scores and the serve / game-over sequence.
// All motion happens on the edge that ends a tick cycle; outputs are registered.
// dbg_state exposes the FSM state: 0 IDLE, 1 SERVE, 2 PLAY, 3 SCORED, 4 OVER.
module ball_controller #(
   parameter int TICK_DIV   = 100000,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int BALL_R     = 4,
   parameter int P1_X       = 20,
   parameter int P2_X       = 619,
   parameter int PADDLE_W   = 8,
   parameter int SERVE_WAIT = 60,
   parameter int WIN_SCORE  = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] p1_y,
   input  logic [10:0] p2_y,
   input  logic        bat_size,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic [3:0]  score_p1,
   output logic [3:0]  score_p2,
   output logic        p1_point,
   output logic        p2_point,
   output logic        game_over,
   output logic [2:0]  dbg_state
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = $clog2(SERVE_WAIT + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SERVE_WAIT - 1);
   localparam logic [10:0]   X_CENTRE  = 11'(SCREEN_W / 2);
   localparam logic [10:0]   Y_CENTRE  = 11'(SCREEN_H / 2);
   localparam logic [10:0]   Y_MAX     = 11'(SCREEN_H - 1 - BALL_R);
   localparam logic [10:0]   Y_MIN     = 11'(BALL_R);
   localparam logic [10:0]   X_MISS_L  = 11'(BALL_R);
   localparam logic [10:0]   X_MISS_R  = 11'(SCREEN_W - 1 - BALL_R);
   // Ball centre columns at which the ball's edge touches a paddle face.
   localparam logic [10:0]   X_HIT_L   = 11'(P1_X + PADDLE_W + BALL_R);
   localparam logic [10:0]   X_HIT_R   = 11'(P2_X - PADDLE_W + 1 - BALL_R);
   // Paddle half-height plus ball half-size: largest centre distance that hits.
   localparam logic [10:0]   REACH_S   = 11'(40 + BALL_R);
   localparam logic [10:0]   REACH_L   = 11'(50 + BALL_R);
   localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SERVE  = 3'd1,
      S_PLAY   = 3'd2,
      S_SCORED = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [10:0]   ball_x_q, ball_x_d;
   logic [10:0]   ball_y_q, ball_y_d;
   logic          dir_x_q, dir_x_d;   // 1: moving right
   logic          dir_y_q, dir_y_d;   // 1: moving down
   logic [3:0]    score_p1_q, score_p1_d;
   logic [3:0]    score_p2_q, score_p2_d;
   logic          p1_point_q, p1_point_d;
   logic          p2_point_q, p2_point_d;
   logic          game_over_q, game_over_d;

   logic          tick;
   logic [10:0]   reach;
   logic [10:0]   dist1, dist2;
   logic          hit_left, hit_right, miss_left, miss_right;

   // Free-running tick divider, active in every state.
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // Paddle contact and miss detection from the current ball position.
   always_comb begin
      reach      = bat_size ? REACH_S : REACH_L;
      dist1      = (ball_y_q >= p1_y) ? (ball_y_q - p1_y) : (p1_y - ball_y_q);
      dist2      = (ball_y_q >= p2_y) ? (ball_y_q - p2_y) : (p2_y - ball_y_q);
      hit_left   = !dir_x_q && (ball_x_q == X_HIT_L) && (dist1 <= reach);
      hit_right  = dir_x_q && (ball_x_q == X_HIT_R) && (dist2 <= reach);
      miss_left  = !dir_x_q && (ball_x_q == X_MISS_L);
      miss_right = dir_x_q && (ball_x_q == X_MISS_R);
   end

   // Game FSM: next state, ball motion, scoring and point pulses.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      score_p1_d = score_p1_q;
      score_p2_d = score_p2_q;
      p1_point_d = 1'b0;
      p2_point_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            ball_x_d = X_CENTRE;
            ball_y_d = Y_CENTRE;
            if (start) begin
               state_d = S_SERVE;
               wait_d  = '0;
            end
         end

         S_SERVE: begin
            ball_x_d = X_CENTRE;
            ball_y_d = Y_CENTRE;
            if (tick) begin
               if (wait_q == WAIT_LAST) begin
                  state_d = S_PLAY;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + WW'(1);
               end
            end
         end

         S_PLAY: begin
            if (tick) begin
               // Vertical motion with wall reflection.
               if (dir_y_q && (ball_y_q == Y_MAX)) begin
                  dir_y_d  = 1'b0;
                  ball_y_d = ball_y_q - 11'd1;
               end else if (!dir_y_q && (ball_y_q == Y_MIN)) begin
                  dir_y_d  = 1'b1;
                  ball_y_d = ball_y_q + 11'd1;
               end else begin
                  ball_y_d = dir_y_q ? ball_y_q + 11'd1 : ball_y_q - 11'd1;
               end

               // Horizontal motion; a paddle hit wins over a miss.
               if (hit_left) begin
                  dir_x_d  = 1'b1;
                  ball_x_d = ball_x_q + 11'd1;
               end else if (hit_right) begin
                  dir_x_d  = 1'b0;
                  ball_x_d = ball_x_q - 11'd1;
               end else if (miss_left) begin
                  score_p2_d = score_p2_q + 4'd1;
                  p2_point_d = 1'b1;
                  ball_y_d   = ball_y_q;
                  state_d    = S_SCORED;
                  wait_d     = '0;
               end else if (miss_right) begin
                  score_p1_d = score_p1_q + 4'd1;
                  p1_point_d = 1'b1;
                  ball_y_d   = ball_y_q;
                  state_d    = S_SCORED;
                  wait_d     = '0;
               end else begin
                  ball_x_d = dir_x_q ? ball_x_q + 11'd1 : ball_x_q - 11'd1;
               end
            end
         end

         S_SCORED: begin
            if (tick) begin
               if (wait_q == WAIT_LAST) begin
                  // The ball was travelling toward the conceding player when it
                  // went out, so keeping dir_x serves toward that player.
                  ball_x_d = X_CENTRE;
                  ball_y_d = Y_CENTRE;
                  dir_x_d  = dir_x_q;
                  wait_d   = '0;
                  if ((score_p1_q == WIN) || (score_p2_q == WIN)) begin
                     state_d = S_OVER;
                  end else begin
                     state_d = S_SERVE;
                  end
               end else begin
                  wait_d = wait_q + WW'(1);
               end
            end
         end

         S_OVER: begin
            ball_x_d = X_CENTRE;
            ball_y_d = Y_CENTRE;
            if (start) begin
               score_p1_d = '0;
               score_p2_d = '0;
               state_d    = S_SERVE;
               wait_d     = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      game_over_d = (state_d == S_OVER);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tick_cnt_q  <= '0;
         wait_q      <= '0;
         ball_x_q    <= X_CENTRE;
         ball_y_q    <= Y_CENTRE;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         score_p1_q  <= '0;
         score_p2_q  <= '0;
         p1_point_q  <= 1'b0;
         p2_point_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         wait_q      <= wait_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         score_p1_q  <= score_p1_d;
         score_p2_q  <= score_p2_d;
         p1_point_q  <= p1_point_d;
         p2_point_q  <= p2_point_d;
         game_over_q <= game_over_d;
      end
   end

   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign score_p1  = score_p1_q;
   assign score_p2  = score_p2_q;
   assign p1_point  = p1_point_q;
   assign p2_point  = p2_point_q;
   assign game_over = game_over_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: directed rallies with hand-computed ball trajectories
// (TICK_DIV=2, SERVE_WAIT=2, WIN_SCORE=2). Everything is driven and sampled
// on the falling edge; ticks land on even rising edges after reset release.
module tb_ball_controller;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SERVE  = 3'd1;
   localparam logic [2:0] ST_PLAY   = 3'd2;
   localparam logic [2:0] ST_SCORED = 3'd3;
   localparam logic [2:0] ST_OVER   = 3'd4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [10:0] p1_y;
   logic [10:0] p2_y;
   logic        bat_size;
   logic [10:0] ball_x;
   logic [10:0] ball_y;
   logic [3:0]  score_p1;
   logic [3:0]  score_p2;
   logic        p1_point;
   logic        p2_point;
   logic        game_over;
   logic [2:0]  dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;   // rising edges since the last reset release

   ball_controller #(
      .TICK_DIV  (2),
      .SERVE_WAIT(2),
      .WIN_SCORE (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .p1_y     (p1_y),
      .p2_y     (p2_y),
      .bat_size (bat_size),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .score_p1 (score_p1),
      .score_p2 (score_p2),
      .p1_point (p1_point),
      .p2_point (p2_point),
      .game_over(game_over),
      .dbg_state(dbg_state)
   );

   // Clock and reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "bench time limit");
   end

   // Driver tasks
   task automatic step_cycle();
      @(negedge clk);
      cyc++;
   endtask

   task automatic next_tick();
      step_cycle();
      if (cyc % 2 != 0) step_cycle();
   endtask

   task automatic run_ticks(input int n);
      repeat (n) next_tick();
   endtask

   // Scenario tasks
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      step_cycle();
      step_cycle();
      rst = 1'b0;
      cyc = 0;
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      tests_run++;
      if (ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL reset_ball: got (%0d,%0d) expected (320,240)", ball_x, ball_y); end
      tests_run++;
      if (score_p1 !== 4'd0 || score_p2 !== 4'd0) begin tests_failed++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score_p1, score_p2); end
      tests_run++;
      if (game_over !== 1'b0 || p1_point !== 1'b0 || p2_point !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got go=%0b p1=%0b p2=%0b expected 0 0 0", game_over, p1_point, p2_point); end
      run_ticks(3);
      tests_run++;
      if (dbg_state !== ST_IDLE || ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL idle_hold: got st=%0d (%0d,%0d) expected st=0 (320,240)", dbg_state, ball_x, ball_y); end
   endtask

   task automatic test_start();
      start = 1'b1;
      step_cycle();
      start = 1'b0;
      tests_run++;
      if (dbg_state !== ST_SERVE) begin tests_failed++; $display("FAIL start_to_serve: got %0d expected %0d", dbg_state, ST_SERVE); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SERVE || ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL serve_hold: got st=%0d (%0d,%0d) expected st=1 (320,240)", dbg_state, ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_PLAY) begin tests_failed++; $display("FAIL serve_to_play: got %0d expected %0d", dbg_state, ST_PLAY); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd321 || ball_y !== 11'd241) begin tests_failed++; $display("FAIL first_step: got (%0d,%0d) expected (321,241)", ball_x, ball_y); end
   endtask

   // Play tick 1 -> 237: bottom wall reflection at y=475.
   task automatic test_wall_bounce();
      run_ticks(234);
      tests_run++;
      if (ball_x !== 11'd555 || ball_y !== 11'd475) begin tests_failed++; $display("FAIL bottom_wall_reach: got (%0d,%0d) expected (555,475)", ball_x, ball_y); end
      start = 1'b1;
      step_cycle();
      start = 1'b0;
      tests_run++;
      if (dbg_state !== ST_PLAY) begin tests_failed++; $display("FAIL start_ignored_play: got %0d expected %0d", dbg_state, ST_PLAY); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd556 || ball_y !== 11'd474) begin tests_failed++; $display("FAIL bottom_wall_bounce: got (%0d,%0d) expected (556,474)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd557 || ball_y !== 11'd473) begin tests_failed++; $display("FAIL bottom_wall_after: got (%0d,%0d) expected (557,473)", ball_x, ball_y); end
   endtask

   // Play tick 237 -> 290: right paddle at p2_y=382, ball y=422 (dist 40, bat 40).
   task automatic test_right_hit();
      run_ticks(51);
      tests_run++;
      if (ball_x !== 11'd608 || ball_y !== 11'd422) begin tests_failed++; $display("FAIL right_hit_reach: got (%0d,%0d) expected (608,422)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd607 || ball_y !== 11'd421) begin tests_failed++; $display("FAIL right_hit_bounce: got (%0d,%0d) expected (607,421)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd606 || ball_y !== 11'd420) begin tests_failed++; $display("FAIL right_hit_after: got (%0d,%0d) expected (606,420)", ball_x, ball_y); end
   endtask

   // Play tick 290 -> 707: top wall reflection at y=4.
   task automatic test_top_wall();
      run_ticks(416);
      tests_run++;
      if (ball_x !== 11'd190 || ball_y !== 11'd4) begin tests_failed++; $display("FAIL top_wall_reach: got (%0d,%0d) expected (190,4)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd189 || ball_y !== 11'd5) begin tests_failed++; $display("FAIL top_wall_bounce: got (%0d,%0d) expected (189,5)", ball_x, ball_y); end
   endtask

   // Play tick 707 -> 865: left paddle, bat 50, p1_y=216 vs y=162 (dist 54, limit).
   task automatic test_left_hit();
      run_ticks(157);
      tests_run++;
      if (ball_x !== 11'd32 || ball_y !== 11'd162) begin tests_failed++; $display("FAIL left_hit_reach: got (%0d,%0d) expected (32,162)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd33 || ball_y !== 11'd163) begin tests_failed++; $display("FAIL left_hit_bounce: got (%0d,%0d) expected (33,163)", ball_x, ball_y); end
   endtask

   // Play tick 865 -> 1468: right paddle at p2_y=167, ball y=212 (dist 45, bat 40).
   task automatic test_right_miss();
      run_ticks(312);
      tests_run++;
      if (ball_x !== 11'd345 || ball_y !== 11'd475) begin tests_failed++; $display("FAIL leg4_wall: got (%0d,%0d) expected (345,475)", ball_x, ball_y); end
      run_ticks(263);
      tests_run++;
      if (ball_x !== 11'd608 || ball_y !== 11'd212) begin tests_failed++; $display("FAIL right_pass_reach: got (%0d,%0d) expected (608,212)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (ball_x !== 11'd609 || ball_y !== 11'd211) begin tests_failed++; $display("FAIL right_pass_through: got (%0d,%0d) expected (609,211)", ball_x, ball_y); end
      run_ticks(26);
      tests_run++;
      if (ball_x !== 11'd635 || ball_y !== 11'd185 || p1_point !== 1'b0) begin tests_failed++; $display("FAIL right_edge: got (%0d,%0d) pulse=%0b expected (635,185) pulse=0", ball_x, ball_y, p1_point); end
      next_tick();
      tests_run++;
      if (p1_point !== 1'b1 || p2_point !== 1'b0) begin tests_failed++; $display("FAIL p1_point_pulse: got p1=%0b p2=%0b expected p1=1 p2=0", p1_point, p2_point); end
      tests_run++;
      if (score_p1 !== 4'd1 || score_p2 !== 4'd0) begin tests_failed++; $display("FAIL p1_score_one: got %0d/%0d expected 1/0", score_p1, score_p2); end
      tests_run++;
      if (dbg_state !== ST_SCORED || ball_x !== 11'd635 || ball_y !== 11'd185) begin tests_failed++; $display("FAIL right_miss_frozen: got st=%0d (%0d,%0d) expected st=3 (635,185)", dbg_state, ball_x, ball_y); end
      step_cycle();
      tests_run++;
      if (p1_point !== 1'b0) begin tests_failed++; $display("FAIL p1_point_width: got %0b expected 0", p1_point); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SCORED || ball_x !== 11'd635 || ball_y !== 11'd185) begin tests_failed++; $display("FAIL scored_hold: got st=%0d (%0d,%0d) expected st=3 (635,185)", dbg_state, ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SERVE || ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL scored_to_serve: got st=%0d (%0d,%0d) expected st=1 (320,240)", dbg_state, ball_x, ball_y); end
      next_tick();
      next_tick();
      tests_run++;
      if (dbg_state !== ST_PLAY) begin tests_failed++; $display("FAIL reserve_play: got %0d expected %0d", dbg_state, ST_PLAY); end
   endtask

   // Serve toward the right (p2 conceded), dir_y kept up; p2 far away -> p1 wins.
   task automatic test_game_over();
      next_tick();
      tests_run++;
      if (ball_x !== 11'd321 || ball_y !== 11'd239) begin tests_failed++; $display("FAIL serve2_first_step: got (%0d,%0d) expected (321,239)", ball_x, ball_y); end
      run_ticks(314);
      tests_run++;
      if (ball_x !== 11'd635 || ball_y !== 11'd83) begin tests_failed++; $display("FAIL serve2_right_edge: got (%0d,%0d) expected (635,83)", ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (p1_point !== 1'b1 || score_p1 !== 4'd2 || score_p2 !== 4'd0) begin tests_failed++; $display("FAIL second_point: got pulse=%0b score %0d/%0d expected pulse=1 score 2/0", p1_point, score_p1, score_p2); end
      tests_run++;
      if (game_over !== 1'b0) begin tests_failed++; $display("FAIL over_early: got %0b expected 0", game_over); end
      start = 1'b1;
      next_tick();
      start = 1'b0;
      tests_run++;
      if (dbg_state !== ST_SCORED) begin tests_failed++; $display("FAIL start_ignored_scored: got %0d expected %0d", dbg_state, ST_SCORED); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_OVER || game_over !== 1'b1) begin tests_failed++; $display("FAIL game_over_enter: got st=%0d go=%0b expected st=4 go=1", dbg_state, game_over); end
      tests_run++;
      if (ball_x !== 11'd320 || ball_y !== 11'd240 || score_p1 !== 4'd2) begin tests_failed++; $display("FAIL game_over_ball: got (%0d,%0d) p1=%0d expected (320,240) p1=2", ball_x, ball_y, score_p1); end
      run_ticks(3);
      tests_run++;
      if (game_over !== 1'b1 || score_p1 !== 4'd2 || score_p2 !== 4'd0) begin tests_failed++; $display("FAIL game_over_hold: got go=%0b %0d/%0d expected go=1 2/0", game_over, score_p1, score_p2); end
   endtask

   task automatic test_restart();
      start = 1'b1;
      step_cycle();
      start = 1'b0;
      tests_run++;
      if (dbg_state !== ST_SERVE || game_over !== 1'b0) begin tests_failed++; $display("FAIL restart_state: got st=%0d go=%0b expected st=1 go=0", dbg_state, game_over); end
      tests_run++;
      if (score_p1 !== 4'd0 || score_p2 !== 4'd0) begin tests_failed++; $display("FAIL restart_scores: got %0d/%0d expected 0/0", score_p1, score_p2); end
      next_tick();
      next_tick();
      tests_run++;
      if (dbg_state !== ST_PLAY) begin tests_failed++; $display("FAIL restart_play: got %0d expected %0d", dbg_state, ST_PLAY); end
   endtask

   // Same opening as the first rally (right/down from centre), p1 paddle far away.
   task automatic test_left_miss();
      run_ticks(289);
      tests_run++;
      if (ball_x !== 11'd607 || ball_y !== 11'd421) begin tests_failed++; $display("FAIL game2_right_hit: got (%0d,%0d) expected (607,421)", ball_x, ball_y); end
      run_ticks(576);
      tests_run++;
      if (ball_x !== 11'd31 || ball_y !== 11'd163) begin tests_failed++; $display("FAIL left_pass_through: got (%0d,%0d) expected (31,163)", ball_x, ball_y); end
      run_ticks(27);
      tests_run++;
      if (ball_x !== 11'd4 || ball_y !== 11'd190 || p2_point !== 1'b0) begin tests_failed++; $display("FAIL left_edge: got (%0d,%0d) pulse=%0b expected (4,190) pulse=0", ball_x, ball_y, p2_point); end
      next_tick();
      tests_run++;
      if (p2_point !== 1'b1 || p1_point !== 1'b0) begin tests_failed++; $display("FAIL p2_point_pulse: got p2=%0b p1=%0b expected p2=1 p1=0", p2_point, p1_point); end
      tests_run++;
      if (score_p2 !== 4'd1 || score_p1 !== 4'd0) begin tests_failed++; $display("FAIL p2_score_one: got %0d/%0d expected 0/1", score_p1, score_p2); end
      step_cycle();
      tests_run++;
      if (p2_point !== 1'b0) begin tests_failed++; $display("FAIL p2_point_width: got %0b expected 0", p2_point); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SCORED || ball_x !== 11'd4 || ball_y !== 11'd190) begin tests_failed++; $display("FAIL left_miss_frozen: got st=%0d (%0d,%0d) expected st=3 (4,190)", dbg_state, ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SERVE || ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL left_miss_centre: got st=%0d (%0d,%0d) expected st=1 (320,240)", dbg_state, ball_x, ball_y); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_SERVE) begin tests_failed++; $display("FAIL left_miss_serve: got %0d expected %0d", dbg_state, ST_SERVE); end
      next_tick();
      tests_run++;
      if (dbg_state !== ST_PLAY) begin tests_failed++; $display("FAIL left_miss_play: got %0d expected %0d", dbg_state, ST_PLAY); end
   endtask

   task automatic test_mid_play_reset();
      run_ticks(3);
      step_cycle();
      rst = 1'b1;
      step_cycle();
      tests_run++;
      if (dbg_state !== ST_IDLE || ball_x !== 11'd320 || ball_y !== 11'd240) begin tests_failed++; $display("FAIL midplay_reset_state: got st=%0d (%0d,%0d) expected st=0 (320,240)", dbg_state, ball_x, ball_y); end
      tests_run++;
      if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || p1_point !== 1'b0 || p2_point !== 1'b0 || game_over !== 1'b0) begin tests_failed++; $display("FAIL midplay_reset_flags: got %0d/%0d p1=%0b p2=%0b go=%0b expected 0/0 0 0 0", score_p1, score_p2, p1_point, p2_point, game_over); end
      rst = 1'b0;
      cyc = 0;
      run_ticks(2);
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL after_reset_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
   endtask

   // Scenario sequence and final report
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      p1_y     = 11'd216;
      p2_y     = 11'd382;
      bat_size = 1'b1;

      test_reset();
      test_start();
      test_wall_bounce();
      test_right_hit();
      bat_size = 1'b0;
      test_top_wall();
      test_left_hit();
      bat_size = 1'b1;
      p2_y     = 11'd167;
      test_right_miss();
      p2_y     = 11'd400;
      test_game_over();
      test_restart();
      p1_y     = 11'd400;
      p2_y     = 11'd382;
      test_left_miss();
      test_mid_play_reset();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
